// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ready handshake
// and holds the latched instruction for decode until it is consumed.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] pc,
    output logic        instr_valid,
    input  logic        advance,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    output logic [31:0] instr_count
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] count_q;
    logic            req_q;
    logic            valid_q;

    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] jump_tgt;
    logic [XLEN-1:0] br_off;
    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] next_pc_d;

    // Next-PC select: jump beats taken branch beats sequential.
    always_comb begin
        pc4       = pc_q + XLEN'(4);
        jump_tgt  = {pc4[31:28], instr_q[25:0], 2'b00};
        br_off    = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        br_tgt    = pc4 + br_off;
        next_pc_d = pc4;
        if (jump) begin
            next_pc_d = jump_tgt;
        end else if (branch && zero) begin
            next_pc_d = br_tgt;
        end
    end

    // Fetch FSM with registered request/valid flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC_ALIGNED;
            pc_q       <= RESET_PC_ALIGNED;
            instr_q    <= '0;
            count_q    <= '0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_REQ;
                    req_q   <= 1'b1;
                end
                S_REQ: begin
                    if (imem_ready) begin
                        instr_q <= imem_rdata;
                        pc_q    <= fetch_pc_q;
                        state_q <= S_HOLD;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (advance) begin
                        fetch_pc_q <= next_pc_d;
                        count_q    <= count_q + XLEN'(1);
                        state_q    <= S_REQ;
                        req_q      <= 1'b1;
                        valid_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = fetch_pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign pc          = pc_q;
    assign instr_valid = valid_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, reset corner cases and a
// randomized run checked against a transaction-level next-PC model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc;
    logic        instr_valid;
    logic        advance;
    logic        branch;
    logic        zero;
    logic        jump;
    logic [31:0] instr_count;

    int unsigned checks = 0;
    int unsigned errors = 0;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .pc          (pc),
        .instr_valid (instr_valid),
        .advance     (advance),
        .branch      (branch),
        .zero        (zero),
        .jump        (jump),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        int unsigned waits;
        logic        b;
        logic        z;
        logic        j;
        logic [31:0] addr;
        logic [31:0] nxt;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(logic [31:0] word, int unsigned waits, logic b, logic z,
                                logic j, logic [31:0] addr, logic [31:0] nxt);
        vec_t v;
        v.word = word; v.waits = waits; v.b = b; v.z = z; v.j = j;
        v.addr = addr; v.nxt = nxt;
        return v;
    endfunction

    // Reference next-PC computed from the architectural rules with plain arithmetic.
    function automatic logic [31:0] model_next(logic [31:0] cur, logic [31:0] w,
                                               logic b, logic z, logic j);
        logic [31:0] p4;
        int          off;
        p4 = cur + 32'd4;
        if (j) return (p4 & 32'hF000_0000) | ({6'b0, w[25:0]} * 32'd4);
        if (b && z) begin
            off = int'($signed(w[15:0])) * 4;
            return p4 + 32'(off);
        end
        return p4;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(string tag);
        chk({tag, "_req"},   32'(imem_req), 32'd0);
        chk({tag, "_addr"},  imem_addr, 32'd0);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_instr"}, instr, 32'd0);
        chk({tag, "_op"},    32'(opcode), 32'd0);
        chk({tag, "_pc"},    pc, 32'd0);
        chk({tag, "_cnt"},   instr_count, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cnt_exp;
        logic [31:0] m_pc;
        logic [31:0] w;
        logic        b, z, j;

        vecs[0]  = mk(32'h1800_0005, 0, 0, 0, 0, 32'h0000_0000, 32'h0000_0004);
        vecs[1]  = mk(32'h2002_0001, 0, 0, 0, 0, 32'h0000_0004, 32'h0000_0008);
        vecs[2]  = mk(32'h8C43_0010, 3, 0, 0, 0, 32'h0000_0008, 32'h0000_000C);
        vecs[3]  = mk(32'h0000_0020, 0, 0, 0, 0, 32'h0000_000C, 32'h0000_0010);
        vecs[4]  = mk(32'h0800_0010, 0, 0, 0, 1, 32'h0000_0010, 32'h0000_0040);
        vecs[5]  = mk(32'h1000_FFFE, 0, 1, 1, 0, 32'h0000_0040, 32'h0000_003C);
        vecs[6]  = mk(32'h0800_0010, 1, 0, 0, 1, 32'h0000_003C, 32'h0000_0040);
        vecs[7]  = mk(32'h1000_FFFE, 0, 1, 0, 0, 32'h0000_0040, 32'h0000_0044);
        vecs[8]  = mk(32'h1000_FFED, 0, 1, 1, 0, 32'h0000_0044, 32'hFFFF_FFFC);
        vecs[9]  = mk(32'h0000_0020, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'h0000_0000);
        vecs[10] = mk(32'h0BFF_FFFF, 0, 0, 0, 1, 32'h0000_0000, 32'h0FFF_FFFC);
        vecs[11] = mk(32'h0000_0020, 2, 0, 0, 0, 32'h0FFF_FFFC, 32'h1000_0000);
        vecs[12] = mk(32'h1000_0003, 0, 1, 1, 0, 32'h1000_0000, 32'h1000_0010);
        vecs[13] = mk(32'h0800_0004, 0, 1, 1, 1, 32'h1000_0010, 32'h1000_0010);
        vecs[14] = mk(32'h1000_0003, 0, 1, 0, 0, 32'h1000_0010, 32'h1000_0014);

        rst = 1'b1; imem_ready = 1'b0; imem_rdata = '0;
        advance = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0;
        tick();
        tick();
        chk_reset_state("rst");

        rst = 1'b0;
        tick();
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'd0);

        cnt_exp = '0;
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("v%0d_req", i), 32'(imem_req), 32'd1);
            chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
            for (int k = 0; k < int'(vecs[i].waits); k++) begin
                imem_ready = 1'b0; advance = 1'b1; imem_rdata = ~vecs[i].word;
                tick();
                chk($sformatf("v%0d_wait_addr", i), imem_addr, vecs[i].addr);
                chk($sformatf("v%0d_wait_valid", i), 32'(instr_valid), 32'd0);
                chk($sformatf("v%0d_wait_cnt", i), instr_count, cnt_exp);
            end
            advance = 1'b0; imem_ready = 1'b1; imem_rdata = vecs[i].word;
            tick();
            imem_ready = 1'b0;
            chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'd1);
            chk($sformatf("v%0d_instr", i), instr, vecs[i].word);
            chk($sformatf("v%0d_op", i), 32'(opcode), 32'(vecs[i].word[31:26]));
            chk($sformatf("v%0d_pc", i), pc, vecs[i].addr);
            chk($sformatf("v%0d_hold_req", i), 32'(imem_req), 32'd0);
            advance = 1'b1; branch = vecs[i].b; zero = vecs[i].z; jump = vecs[i].j;
            imem_ready = 1'b1; imem_rdata = ~vecs[i].word;
            tick();
            advance = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0; imem_ready = 1'b0;
            cnt_exp = cnt_exp + 32'd1;
            chk($sformatf("v%0d_next", i), imem_addr, vecs[i].nxt);
            chk($sformatf("v%0d_cnt", i), instr_count, cnt_exp);
            chk($sformatf("v%0d_novalid", i), 32'(instr_valid), 32'd0);
            chk($sformatf("v%0d_keep", i), instr, vecs[i].word);
        end

        // Reset lands on a request cycle with ready and advance both high.
        rst = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF; advance = 1'b1;
        tick();
        chk_reset_state("midrst");
        rst = 1'b0; imem_ready = 1'b0; advance = 1'b0;
        tick();
        chk("post_rst_req", 32'(imem_req), 32'd1);
        chk("post_rst_addr", imem_addr, 32'd0);

        m_pc = 32'd0;
        cnt_exp = 32'd0;
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                imem_ready = 1'b0; advance = 1'($urandom); imem_rdata = $urandom;
                tick();
                chk("rnd_wait_addr", imem_addr, m_pc);
                chk("rnd_wait_valid", 32'(instr_valid), 32'd0);
                chk("rnd_wait_cnt", instr_count, cnt_exp);
            end
            w = $urandom;
            advance = 1'($urandom); imem_ready = 1'b1; imem_rdata = w;
            tick();
            chk("rnd_valid", 32'(instr_valid), 32'd1);
            chk("rnd_instr", instr, w);
            chk("rnd_pc", pc, m_pc);
            chk("rnd_cnt_fetch", instr_count, cnt_exp);
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                advance = 1'b0; imem_ready = 1'($urandom); imem_rdata = $urandom;
                tick();
                chk("rnd_hold_instr", instr, w);
                chk("rnd_hold_pc", pc, m_pc);
                chk("rnd_hold_valid", 32'(instr_valid), 32'd1);
            end
            b = 1'($urandom); z = 1'($urandom); j = 1'($urandom_range(0, 3) == 0);
            advance = 1'b1; branch = b; zero = z; jump = j;
            imem_ready = 1'($urandom); imem_rdata = $urandom;
            tick();
            advance = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0; imem_ready = 1'b0;
            m_pc = model_next(m_pc, w, b, z, j);
            cnt_exp = cnt_exp + 32'd1;
            chk("rnd_next", imem_addr, m_pc);
            chk("rnd_cnt", instr_count, cnt_exp);
            chk("rnd_req", 32'(imem_req), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
